// File: rtl/game_pkg.sv
// Shared phase encodings, counter widths and default timing for the paddle-and-ball game.
// Pure declarations; no logic, no latency, no flow control.
package game_pkg;

    typedef enum logic [2:0] {
        SERVE = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        LOST  = 3'd3,
        OVER  = 3'd4,
        WIN   = 3'd5
    } phase_e;

    localparam int SCORE_W = 8;
    localparam int LIVES_W = 2;

    localparam int DEF_STEP_DIV   = 3;
    localparam int DEF_LOST_TICKS = 20;
    localparam int DEF_LIVES      = 3;

endpackage

// File: rtl/game_sequencer_if.sv
// Button/ball-engine inputs and phase/status outputs of the game sequencer.
// Plain wires; the master drives the buttons and engine pulses, the slave drives status.
interface game_sequencer_if;
    import game_pkg::*;

    logic               throw;
    logic               pause;
    logic               ball_lost;
    logic               brick_hit;
    logic               all_cleared;
    logic               hold_ball;
    logic               step_en;
    logic [2:0]         phase;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic               game_over;
    logic               win;

    modport master (
        output throw, pause, ball_lost, brick_hit, all_cleared,
        input  hold_ball, step_en, phase, lives, score, game_over, win
    );

    modport slave (
        input  throw, pause, ball_lost, brick_hit, all_cleared,
        output hold_ball, step_en, phase, lives, score, game_over, win
    );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced level button: rise is high while btn is high and was low last cycle.
// Edge is combinational from btn against one registered sample; no flow control.
module btn_edge (
    input  logic buttonclk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    // Clearing the sample in reset lets a button held through reset yield one edge afterwards.
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-phase controller: serve/play/pause/lost/over/win sequencing, ball step pacing, lives and score.
// All outputs registered or decoded from registers (1-cycle input-to-output); no backpressure.
module game_sequencer
    import game_pkg::*;
#(
    parameter int STEP_DIV   = DEF_STEP_DIV,
    parameter int LOST_TICKS = DEF_LOST_TICKS,
    parameter int LIVES      = DEF_LIVES
) (
    input  logic            buttonclk,
    input  logic            reset,
    game_sequencer_if.slave bus
);

    localparam logic [3:0]         STEP_LAST  = 4'(STEP_DIV - 1);
    localparam logic [5:0]         LOST_LAST  = 6'(LOST_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] LIFE_ONE   = LIVES_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    phase_e             state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         step_cnt_q, step_cnt_d;
    logic [5:0]         lost_cnt_q, lost_cnt_d;
    logic               step_en_q, step_en_d;
    logic               throw_e;
    logic               pause_e;

    btn_edge u_throw_edge (
        .buttonclk (buttonclk),
        .reset     (reset),
        .btn       (bus.throw),
        .rise      (throw_e)
    );

    btn_edge u_pause_edge (
        .buttonclk (buttonclk),
        .reset     (reset),
        .btn       (bus.pause),
        .rise      (pause_e)
    );

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            state_q    <= SERVE;
            lives_q    <= LIVES_INIT;
            score_q    <= '0;
            step_cnt_q <= '0;
            lost_cnt_q <= '0;
            step_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            step_cnt_q <= step_cnt_d;
            lost_cnt_q <= lost_cnt_d;
            step_en_q  <= step_en_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        score_d    = score_q;
        step_cnt_d = step_cnt_q;
        lost_cnt_d = lost_cnt_q;
        step_en_d  = 1'b0;

        case (state_q)
            SERVE: begin
                if (throw_e) begin
                    state_d    = PLAY;
                    step_cnt_d = '0;
                end
            end
            PLAY: begin
                if (bus.brick_hit && (score_q != SCORE_MAX)) begin
                    score_d = score_q + 1'b1;
                end
                if (bus.all_cleared) begin
                    state_d = WIN;
                end else if (bus.ball_lost) begin
                    if (lives_q <= LIFE_ONE) begin
                        state_d = OVER;
                        lives_d = '0;
                    end else begin
                        state_d = LOST;
                        lives_d = lives_q - 1'b1;
                    end
                end else if (pause_e) begin
                    state_d = PAUSE;
                end else begin
                    // Only cycles that stay in PLAY advance pacing, so a pause never drops or adds a step.
                    step_en_d  = (step_cnt_q == STEP_LAST);
                    step_cnt_d = step_en_d ? 4'd0 : step_cnt_q + 4'd1;
                end
            end
            PAUSE: begin
                if (pause_e) begin
                    state_d = PLAY;
                end
            end
            LOST: begin
                if (lost_cnt_q == LOST_LAST) begin
                    state_d    = SERVE;
                    lost_cnt_d = '0;
                end else begin
                    lost_cnt_d = lost_cnt_q + 6'd1;
                end
            end
            OVER, WIN: begin
                if (throw_e) begin
                    state_d = SERVE;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                end
            end
            default: begin
                state_d = SERVE;
            end
        endcase
    end

    assign bus.phase     = state_q;
    assign bus.hold_ball = (state_q == SERVE);
    assign bus.game_over = (state_q == OVER);
    assign bus.win       = (state_q == WIN);
    assign bus.step_en   = step_en_q;
    assign bus.lives     = lives_q;
    assign bus.score     = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: vector table, directed corner sequences and random traffic vs a reference model.
module tb_game_sequencer;

    localparam int STEP_DIV   = 3;
    localparam int LOST_TICKS = 20;
    localparam int LIVES      = 3;

    localparam int PH_SERVE = 0;
    localparam int PH_PLAY  = 1;
    localparam int PH_PAUSE = 2;
    localparam int PH_LOST  = 3;
    localparam int PH_OVER  = 4;
    localparam int PH_WIN   = 5;

    logic buttonclk;
    logic reset;

    game_sequencer_if bif ();

    game_sequencer #(
        .STEP_DIV   (STEP_DIV),
        .LOST_TICKS (LOST_TICKS),
        .LIVES      (LIVES)
    ) dut (
        .buttonclk (buttonclk),
        .reset     (reset),
        .bus       (bif)
    );

    initial begin
        buttonclk = 1'b0;
        forever #5 buttonclk = ~buttonclk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: phases as integers, pacing as a running count of PLAY cycles
    int m_phase, m_lives, m_score, m_step, m_adv, m_lost_left;
    bit m_tp, m_pp;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit te, pe;
        int nstep;
        if (reset) begin
            m_phase = PH_SERVE; m_lives = LIVES; m_score = 0; m_step = 0;
            m_adv = 0; m_lost_left = 0; m_tp = 0; m_pp = 0;
        end else begin
            te = bif.throw && !m_tp;
            pe = bif.pause && !m_pp;
            m_tp = bif.throw;
            m_pp = bif.pause;
            nstep = 0;
            case (m_phase)
                PH_SERVE: if (te) begin m_phase = PH_PLAY; m_adv = 0; end
                PH_PLAY: begin
                    if (bif.brick_hit) m_score = (m_score >= 255) ? 255 : m_score + 1;
                    if (bif.all_cleared) m_phase = PH_WIN;
                    else if (bif.ball_lost) begin
                        if (m_lives == 1) begin m_phase = PH_OVER; m_lives = 0; end
                        else begin m_phase = PH_LOST; m_lives--; m_lost_left = LOST_TICKS; end
                    end else if (pe) m_phase = PH_PAUSE;
                    else begin
                        m_adv++;
                        nstep = (m_adv % STEP_DIV == 0) ? 1 : 0;
                    end
                end
                PH_PAUSE: if (pe) m_phase = PH_PLAY;
                PH_LOST: begin
                    m_lost_left--;
                    if (m_lost_left == 0) m_phase = PH_SERVE;
                end
                default: if (te) begin m_phase = PH_SERVE; m_lives = LIVES; m_score = 0; end
            endcase
            m_step = nstep;
        end
    endtask

    task automatic compare_all();
        chk("phase", int'(bif.phase), m_phase);
        chk("lives", int'(bif.lives), m_lives);
        chk("score", int'(bif.score), m_score);
        chk("step_en", int'(bif.step_en), m_step);
        chk("hold_ball", int'(bif.hold_ball), (m_phase == PH_SERVE) ? 1 : 0);
        chk("game_over", int'(bif.game_over), (m_phase == PH_OVER) ? 1 : 0);
        chk("win", int'(bif.win), (m_phase == PH_WIN) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge buttonclk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic pulse_throw();
        bif.throw = 1'b1; tick();
        bif.throw = 1'b0; tick();
    endtask

    task automatic wait_for_phase(input int p, input int lim, input string nm);
        int n;
        n = 0;
        while (int'(bif.phase) != p && n < lim) begin
            tick();
            n++;
        end
        chk(nm, int'(bif.phase), p);
    endtask

    typedef struct {
        logic rst, thr, pse, bl, bh, ac;
        int   ph, st, lv;
    } vec_t;

    vec_t vt [16];

    initial begin
        int n;

        // Row i drives cycle i; expectations are the outputs in cycle i+1
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 3};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 3};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 3};
        vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 3};

        reset = 1'b1;
        bif.throw = 1'b0; bif.pause = 1'b0; bif.ball_lost = 1'b0;
        bif.brick_hit = 1'b0; bif.all_cleared = 1'b0;

        for (int i = 0; i < 16; i++) begin
            reset = vt[i].rst; bif.throw = vt[i].thr; bif.pause = vt[i].pse;
            bif.ball_lost = vt[i].bl; bif.brick_hit = vt[i].bh; bif.all_cleared = vt[i].ac;
            tick();
            chk($sformatf("vec%0d_phase", i), int'(bif.phase), vt[i].ph);
            chk($sformatf("vec%0d_step", i), int'(bif.step_en), vt[i].st);
            chk($sformatf("vec%0d_lives", i), int'(bif.lives), vt[i].lv);
        end
        bif.throw = 1'b0; bif.pause = 1'b0;

        // Ball lost with three lives: twenty LOST cycles without steps, back to SERVE
        bif.ball_lost = 1'b1; tick(); bif.ball_lost = 1'b0;
        chk("lost_phase", int'(bif.phase), PH_LOST);
        chk("lost_lives", int'(bif.lives), 2);
        n = 0;
        while (int'(bif.phase) == PH_LOST && n < 100) begin
            chk("lost_no_step", int'(bif.step_en), 0);
            tick();
            n++;
        end
        chk("lost_len", n, LOST_TICKS);
        chk("lost_exit_phase", int'(bif.phase), PH_SERVE);
        chk("lost_exit_hold", int'(bif.hold_ball), 1);

        // Last life lost together with a brick hit
        pulse_throw();
        bif.ball_lost = 1'b1; tick(); bif.ball_lost = 1'b0;
        chk("to_one_life", int'(bif.lives), 1);
        wait_for_phase(PH_SERVE, 60, "lost_timeout");
        pulse_throw();
        bif.ball_lost = 1'b1; bif.brick_hit = 1'b1; tick();
        bif.ball_lost = 1'b0; bif.brick_hit = 1'b0;
        chk("over_phase", int'(bif.phase), PH_OVER);
        chk("over_lives", int'(bif.lives), 0);
        chk("over_score", int'(bif.score), 1);
        chk("over_flag", int'(bif.game_over), 1);
        tick(); tick();
        pulse_throw();
        chk("restart_phase", int'(bif.phase), PH_SERVE);
        chk("restart_lives", int'(bif.lives), 3);
        chk("restart_score", int'(bif.score), 0);

        // all_cleared outranks ball_lost
        pulse_throw();
        bif.all_cleared = 1'b1; bif.ball_lost = 1'b1; tick();
        bif.all_cleared = 1'b0; bif.ball_lost = 1'b0;
        chk("win_phase", int'(bif.phase), PH_WIN);
        chk("win_flag", int'(bif.win), 1);
        chk("win_lives", int'(bif.lives), 3);
        pulse_throw();
        chk("win_restart", int'(bif.phase), PH_SERVE);

        // Pause with the step counter at 1; resume yields a step two PLAY cycles later
        pulse_throw();
        n = 0;
        while (!bif.step_en && n < 20) begin tick(); n++; end
        chk("first_step_seen", int'(bif.step_en), 1);
        tick();
        bif.pause = 1'b1; tick();
        chk("pause_phase", int'(bif.phase), PH_PAUSE);
        repeat (9) tick();
        chk("pause_held", int'(bif.phase), PH_PAUSE);
        bif.pause = 1'b0; tick();
        bif.pause = 1'b1; tick();
        chk("resume_phase", int'(bif.phase), PH_PLAY);
        bif.pause = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!bif.step_en && n < 10);
        chk("resume_gap", n, 2);

        // Score saturation
        bif.brick_hit = 1'b1;
        repeat (255) tick();
        chk("score_255", int'(bif.score), 255);
        tick();
        chk("score_sat", int'(bif.score), 255);
        bif.brick_hit = 1'b0;

        // Reset in PAUSE with throw held
        bif.pause = 1'b1; tick();
        chk("pre_reset_pause", int'(bif.phase), PH_PAUSE);
        bif.throw = 1'b1; reset = 1'b1; tick();
        chk("rst_phase", int'(bif.phase), PH_SERVE);
        chk("rst_score", int'(bif.score), 0);
        reset = 1'b0; tick();
        chk("rst_held_throw", int'(bif.phase), PH_PLAY);
        bif.throw = 1'b0; bif.pause = 1'b0; tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset           = ($urandom_range(0, 699) == 0);
            bif.throw       = ($urandom_range(0, 5) == 0);
            bif.pause       = ($urandom_range(0, 11) == 0);
            bif.ball_lost   = ($urandom_range(0, 39) == 0);
            bif.brick_hit   = ($urandom_range(0, 2) == 0);
            bif.all_cleared = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
